// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button conditioning, run/pause/stop FSM,
// 0.1 s prescaler and wrapping tenths counter for the display.
module stopwatch_ctrl #(
    parameter int TICK_DIV     = 5000000,
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int COUNT_MAX    = 9999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  btn,
    output logic [13:0] number,
    output logic [1:0]  pausa_dis,
    output logic [3:0]  led,
    output logic [1:0]  state,
    output logic        tick
);

    localparam logic [1:0] ST_STOP  = 2'd0;
    localparam logic [1:0] ST_CNT   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_RST   = 2'd3;

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);

    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYC - 1);
    localparam logic [13:0]   CMAX      = 14'(COUNT_MAX);

    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic [3:0]    deb;
    logic [3:0]    deb_q;
    logic [DW-1:0] db_cnt [4];
    logic [3:0]    rel;

    logic [1:0]    next_state;
    logic [13:0]   count;
    logic [13:0]   lap;
    logic [PW-1:0] presc;
    logic          running;
    logic          lap_take;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 4'hF;
            sync2 <= 4'hF;
            deb   <= 4'hF;
            deb_q <= 4'hF;
            for (int k = 0; k < 4; k++) begin
                db_cnt[k] <= '0;
            end
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            deb_q <= deb;
            for (int k = 0; k < 4; k++) begin
                if (sync2[k] != deb[k]) begin
                    if (db_cnt[k] == DB_LAST) begin
                        deb[k]    <= sync2[k];
                        db_cnt[k] <= '0;
                    end else begin
                        db_cnt[k] <= db_cnt[k] + DW'(1);
                    end
                end else begin
                    db_cnt[k] <= '0;
                end
            end
        end
    end

    // Only the rising (release) edge of a debounced level is an event.
    assign rel = deb & ~deb_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RST;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        priority case (1'b1)
            rel[3]: next_state = ST_RST;
            rel[0]: begin
                if (state != ST_RST) begin
                    next_state = ST_STOP;
                end
            end
            rel[1]: begin
                if (state == ST_CNT) begin
                    next_state = ST_PAUSE;
                end else if (state == ST_PAUSE) begin
                    next_state = ST_CNT;
                end
            end
            rel[2]: next_state = ST_CNT;
            default: next_state = state;
        endcase
    end

    always_comb begin
        led       = 4'b1000;
        pausa_dis = 2'd0;
        number    = count;
        unique case (state)
            ST_STOP:  led = 4'b0001;
            ST_CNT:   led = 4'b0100;
            ST_PAUSE: begin
                led       = 4'b0010;
                pausa_dis = 2'd1;
                number    = lap;
            end
            ST_RST:   led = 4'b1000;
        endcase
    end

    assign running  = (state == ST_CNT) || (state == ST_PAUSE);
    assign tick     = running && (presc == TICK_LAST);
    assign lap_take = (state == ST_CNT) && rel[1] && !rel[0];

    // Count keeps running while paused; only the displayed value freezes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            lap   <= '0;
            presc <= '0;
        end else if (rel[3]) begin
            count <= '0;
            lap   <= '0;
            presc <= '0;
        end else begin
            if (running) begin
                if (tick) begin
                    presc <= '0;
                    if (count == CMAX) begin
                        count <= '0;
                    end else begin
                        count <= count + 14'd1;
                    end
                end else begin
                    presc <= presc + PW'(1);
                end
            end else if (state == ST_RST) begin
                presc <= '0;
            end
            if (lap_take) begin
                lap <= count;
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenario with literal checks,
// then random buttons/resets compared every cycle to a model.
module tb_stopwatch_ctrl;

    localparam int TD = 4;
    localparam int DB = 3;
    localparam int CM = 9;

    logic        clk;
    logic        rst_n;
    logic [3:0]  btn;
    logic [13:0] number;
    logic [1:0]  pausa_dis;
    logic [3:0]  led;
    logic [1:0]  state;
    logic        tick;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    stopwatch_ctrl #(
        .TICK_DIV(TD),
        .DEBOUNCE_CYC(DB),
        .COUNT_MAX(CM)
    ) u_dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn(btn),
        .number(number),
        .pausa_dis(pausa_dis),
        .led(led),
        .state(state),
        .tick(tick)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: states 0 stop,1 count,2 pause,3 reset.
    int         m_state;
    int         m_cnt;
    int         m_lap;
    int         m_pre;
    int         m_run [4];
    logic [3:0] m_s1;
    logic [3:0] m_s2;
    logic [3:0] m_deb;
    logic [3:0] m_rel;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 3;
            m_cnt   = 0;
            m_lap   = 0;
            m_pre   = 0;
            m_s1    = 4'hF;
            m_s2    = 4'hF;
            m_deb   = 4'hF;
            m_rel   = 4'h0;
            for (int k = 0; k < 4; k++) m_run[k] = 0;
        end else begin
            int  old_cnt;
            bit  live;
            old_cnt = m_cnt;
            live    = (m_state == 1) || (m_state == 2);
            if (m_rel[3]) begin
                m_state = 3;
                m_cnt   = 0;
                m_lap   = 0;
                m_pre   = 0;
            end else begin
                if (live) begin
                    if (m_pre == TD - 1) begin
                        m_pre = 0;
                        m_cnt = (m_cnt + 1) % (CM + 1);
                    end else begin
                        m_pre++;
                    end
                end else if (m_state == 3) begin
                    m_pre = 0;
                end
                if (m_rel[0]) begin
                    if (m_state != 3) m_state = 0;
                end else if (m_rel[1]) begin
                    if (m_state == 1) begin
                        m_lap   = old_cnt;
                        m_state = 2;
                    end else if (m_state == 2) begin
                        m_state = 1;
                    end
                end else if (m_rel[2]) begin
                    m_state = 1;
                end
            end
            m_rel = 4'h0;
            for (int k = 0; k < 4; k++) begin
                if (m_s2[k] != m_deb[k]) begin
                    m_run[k]++;
                    if (m_run[k] == DB) begin
                        m_deb[k] = m_s2[k];
                        m_run[k] = 0;
                        m_rel[k] = m_deb[k];
                    end
                end else begin
                    m_run[k] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = btn;
        end
    end

    function automatic int exp_led(input int s);
        case (s)
            0:       return 1;
            1:       return 4;
            2:       return 2;
            default: return 8;
        endcase
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            int en;
            int etk;
            en  = (m_state == 2) ? m_lap : m_cnt;
            etk = ((m_state == 1 || m_state == 2)
                   && m_pre == TD - 1) ? 1 : 0;
            chk("state", int'(state), m_state);
            chk("number", int'(number), en);
            chk("pausa", int'(pausa_dis), (m_state == 2) ? 1 : 0);
            chk("led", int'(led), exp_led(m_state));
            chk("tick", int'(tick), etk);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic click(input int k, input int low);
        btn[k] = 1'b0;
        cyc(low);
        btn[k] = 1'b1;
    endtask

    initial begin
        int v;
        int ticks;
        rst_n = 0;
        btn   = 4'hF;
        cyc(2);
        rst_n  = 1;
        chk_en = 1;

        ticks = 0;
        for (int i = 0; i < 50; i++) begin
            cyc(1);
            if (tick) ticks++;
        end
        chk("idle_state", int'(state), 3);
        chk("idle_led", int'(led), 8);
        chk("idle_num", int'(number), 0);
        chk("idle_ticks", ticks, 0);

        click(2, 10);
        cyc(5);
        chk("start_lat5", int'(state), 3);
        cyc(1);
        chk("start_lat6", int'(state), 1);
        cyc(20);
        chk("num_at20", int'(number), 5);
        cyc(20);
        chk("num_wrap40", int'(number), 0);

        click(1, 4);
        cyc(6);
        chk("pause_state", int'(state), 2);
        v = int'(number);
        cyc(40);
        chk("pause_hold", int'(number), v);
        chk("pause_flag", int'(pausa_dis), 1);
        click(1, 4);
        cyc(6);
        chk("resume_state", int'(state), 1);
        chk("resume_flag", int'(pausa_dis), 0);

        click(0, 4);
        cyc(6);
        chk("stop_led", int'(led), 1);
        v = int'(number);
        cyc(20);
        chk("stop_frozen", int'(number), v);

        btn[3] = 1'b0;
        cyc(2);
        btn[3] = 1'b1;
        cyc(12);
        chk("glitch", int'(state), 0);

        click(2, 4);
        cyc(6);
        chk("restart", int'(state), 1);
        btn[0] = 1'b0;
        btn[3] = 1'b0;
        cyc(5);
        btn[0] = 1'b1;
        btn[3] = 1'b1;
        cyc(6);
        chk("dual_state", int'(state), 3);
        chk("dual_num", int'(number), 0);

        click(2, 4);
        cyc(6 + 12);
        chk("pre_rst_num", int'(number), 3);
        #2;
        rst_n = 0;
        #1;
        chk("async_state", int'(state), 3);
        chk("async_num", int'(number), 0);
        chk("async_tick", int'(tick), 0);
        btn[2] = 1'b0;
        cyc(2);
        rst_n = 1;
        cyc(20);
        chk("held_nostart", int'(state), 3);
        btn[2] = 1'b1;
        cyc(6);
        chk("held_release", int'(state), 1);

        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) begin
                btn[$urandom_range(0, 3)] ^= 1'b1;
            end
            if ($urandom_range(0, 699) == 0) begin
                #3;
                rst_n = 0;
                cyc($urandom_range(1, 3));
                #2;
                rst_n = 1;
            end
        end

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
